// File: rtl/cache_slave_responder.sv
// rtl/cache_slave_responder.sv - 4-phase slave endpoint: direct-mapped write-back cache of one-word lines over a backing RAM
module cache_slave_responder #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int MEMADDRBITS  = 8,
    parameter int INDEXBITS    = 4,
    parameter int MISS_PENALTY = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [2:0]              i_operation,
    inout  wire  [ADDRESSWIDTH-1:0] io_addr,
    inout  wire  [DATAWIDTH-1:0]    io_d,
    input  logic                    i_request,
    output logic                    o_valid,
    output logic                    o_evict
);

    localparam int LINES   = 1 << INDEXBITS;
    localparam int WORDS   = 1 << MEMADDRBITS;
    localparam int TAGBITS = MEMADDRBITS - INDEXBITS;
    localparam int CNTW    = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MISS_PENALTY - 1);

    localparam logic [2:0] OP_READ       = 3'd0;
    localparam logic [2:0] OP_WRITE      = 3'd1;
    localparam logic [2:0] OP_INVALIDATE = 3'd2;
    localparam logic [2:0] OP_CLEAR      = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                   r_armed;
    logic [2:0]             r_op;
    logic [MEMADDRBITS-1:0] r_addr;
    logic [DATAWIDTH-1:0]   r_wdata;
    logic [DATAWIDTH-1:0]   r_rdata;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_evict_pend;
    logic                   r_valid;
    logic                   r_evict;
    logic                   r_d_oe;

    // Line and RAM storage kept as flat vectors so reset and CLEAR are single whole-vector assignments.
    logic [LINES-1:0]           r_line_valid;
    logic [LINES-1:0]           r_line_dirty;
    logic [LINES*TAGBITS-1:0]   r_line_tag;
    logic [LINES*DATAWIDTH-1:0] r_line_data;
    logic [WORDS*DATAWIDTH-1:0] r_ram;

    logic [INDEXBITS-1:0]   w_idx;
    logic [TAGBITS-1:0]     w_tag;
    logic [TAGBITS-1:0]     w_line_tag;
    logic [DATAWIDTH-1:0]   w_line_data;
    logic                   w_hit;
    logic                   w_victim_dirty;
    logic                   w_is_rw;
    logic                   w_accept;
    logic                   w_unused_addr;

    assign w_idx          = r_addr[INDEXBITS-1:0];
    assign w_tag          = r_addr[MEMADDRBITS-1:INDEXBITS];
    assign w_line_tag     = r_line_tag[int'(w_idx)*TAGBITS +: TAGBITS];
    assign w_line_data    = r_line_data[int'(w_idx)*DATAWIDTH +: DATAWIDTH];
    assign w_hit          = r_line_valid[w_idx] && (w_line_tag == w_tag);
    assign w_victim_dirty = r_line_valid[w_idx] && r_line_dirty[w_idx];
    assign w_is_rw        = (r_op == OP_READ) || (r_op == OP_WRITE);
    assign w_accept       = (r_state == S_IDLE) && i_request && r_armed;
    assign w_unused_addr  = ^io_addr[ADDRESSWIDTH-1:MEMADDRBITS];

    assign io_addr = {ADDRESSWIDTH{1'bz}};
    assign io_d    = r_d_oe ? r_rdata : {DATAWIDTH{1'bz}};
    assign o_valid = r_valid;
    assign o_evict = r_evict;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_is_rw || w_hit) begin
                    w_next_state = S_RESPOND;
                end else if (w_victim_dirty) begin
                    w_next_state = S_WRITEBACK;
                end else begin
                    w_next_state = S_FILL;
                end
            end
            S_WRITEBACK: w_next_state = S_FILL;
            S_FILL: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: begin
                // Leaving needs valid already raised, so a request dropped early still sees one valid cycle.
                if (r_valid && !i_request) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_armed      <= 1'b0;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_evict_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_evict      <= 1'b0;
            r_d_oe       <= 1'b0;
            r_line_valid <= '0;
            r_line_dirty <= '0;
            r_line_tag   <= '0;
            r_line_data  <= '0;
            r_ram        <= '0;
        end else begin
            if (!i_request) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_operation;
                        r_addr  <= io_addr[MEMADDRBITS-1:0];
                        r_wdata <= io_d;
                    end
                end
                S_LOOKUP: r_cnt <= CNT_LOAD;
                S_WRITEBACK: begin
                    r_ram[int'({w_line_tag, w_idx})*DATAWIDTH +: DATAWIDTH] <= w_line_data;
                    r_evict_pend <= 1'b1;
                    r_cnt        <= CNT_LOAD;
                end
                S_FILL: begin
                    if (r_cnt == '0) begin
                        r_line_data[int'(w_idx)*DATAWIDTH +: DATAWIDTH] <= r_ram[int'(r_addr)*DATAWIDTH +: DATAWIDTH];
                        r_line_tag[int'(w_idx)*TAGBITS +: TAGBITS]      <= w_tag;
                        r_line_valid[w_idx] <= 1'b1;
                        r_line_dirty[w_idx] <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_evict <= r_evict_pend;
                        case (r_op)
                            OP_READ: begin
                                r_rdata <= w_line_data;
                                r_d_oe  <= 1'b1;
                            end
                            OP_WRITE: begin
                                r_line_data[int'(w_idx)*DATAWIDTH +: DATAWIDTH] <= r_wdata;
                                r_line_dirty[w_idx] <= 1'b1;
                            end
                            OP_INVALIDATE: begin
                                if (w_line_tag == w_tag) begin
                                    r_line_valid[w_idx] <= 1'b0;
                                    r_line_dirty[w_idx] <= 1'b0;
                                end
                            end
                            OP_CLEAR: begin
                                r_line_valid <= '0;
                                r_line_dirty <= '0;
                            end
                            default: ;
                        endcase
                    end else if (!i_request) begin
                        r_valid      <= 1'b0;
                        r_evict      <= 1'b0;
                        r_d_oe       <= 1'b0;
                        r_evict_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
